// File: rtl/adc_capture_buf.sv
// ADC AXI4-stream capture into BRAM: arm/trigger/abort control, decimation, length-limited store.
// Optional macro ADC_CAPTURE_TSTAMP_EN adds a free-running cycle counter latched on each accepted trigger.
module adc_capture_buf #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  input  logic [7:0]            cfg_decim,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  armed,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wr_count,
  output logic [31:0]           trig_tstamp
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] wr_next;
  logic [7:0]            decim_q;
  logic [7:0]            dec_cnt_q;
  logic [7:0]            dec_base;
  logic [7:0]            dec_step;
  logic                  accept;
  logic                  store;
  logic                  arm_take;
  logic                  trig_take;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The trigger-cycle beat is decimation index 0, so the counter base is 0 outside CAPTURE.
  always_comb begin
    state_d   = state_q;
    store     = 1'b0;
    arm_take  = 1'b0;
    trig_take = 1'b0;
    accept    = s_tvalid & s_tready;
    wr_next   = wr_count + ADDR_WIDTH'(1);
    dec_base  = (state_q == CAPTURE) ? dec_cnt_q : 8'd0;
    dec_step  = (dec_base == decim_q) ? 8'd0 : dec_base + 8'd1;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            arm_take = 1'b1;
            state_d  = ARMED;
          end
        end
        ARMED: begin
          if (trigger) begin
            trig_take = 1'b1;
            if (len_q == '0) begin
              state_d = DONE;
            end else begin
              store   = accept;
              state_d = (store && wr_next == len_q) ? DONE : CAPTURE;
            end
          end
        end
        CAPTURE: begin
          store = accept && (dec_cnt_q == 8'd0);
          if (store && wr_next == len_q) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s_tready  <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      wr_count  <= '0;
      len_q     <= '0;
      decim_q   <= '0;
      dec_cnt_q <= '0;
    end else begin
      s_tready <= 1'b1;
      bram_we  <= store;
      if (store) begin
        bram_addr <= wr_count;
        bram_din  <= s_tdata;
        wr_count  <= wr_next;
      end
      if (arm_take) begin
        len_q    <= cfg_len;
        decim_q  <= cfg_decim;
        wr_count <= '0;
      end
      // Only accepted beats advance decimation; valid gaps leave it untouched.
      if (trig_take)
        dec_cnt_q <= accept ? dec_step : 8'd0;
      else if (state_q == CAPTURE && !abort && accept)
        dec_cnt_q <= dec_step;
    end
  end

  assign armed = (state_q == ARMED);
  assign busy  = (state_q == CAPTURE);
  assign done  = (state_q == DONE);

`ifdef ADC_CAPTURE_TSTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] tstamp_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cyc_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (trig_take) tstamp_q <= cyc_q;
    end
  end

  assign trig_tstamp = tstamp_q;
`else
  assign trig_tstamp = 32'd0;
`endif

endmodule

// File: tb/tb_adc_capture_buf.sv
// Self-checking bench for adc_capture_buf: directed scenarios plus randomized control/stream traffic,
// compared every cycle against a transaction-level model (ADC_CAPTURE_TSTAMP_EN selects timestamp expectations).
module tb_adc_capture_buf;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;
  localparam logic [DW-1:0] BASE = 32'hA000_0000;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          arm;
  logic          trigger;
  logic          abort;
  logic [AW-1:0] cfg_len;
  logic [7:0]    cfg_decim;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic          armed;
  logic          busy;
  logic          done;
  logic [AW-1:0] wr_count;
  logic [31:0]   trig_tstamp;

  adc_capture_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .arm(arm), .trigger(trigger), .abort(abort), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .armed(armed), .busy(busy), .done(done), .wr_count(wr_count), .trig_tstamp(trig_tstamp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tb_cyc = 0;
  int drive_cyc = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wr_log[$];

  // Reference model: state named after the spec, stores chosen by beat index modulo (decim+1).
  int            m_state;
  int            m_len;
  int            m_decim;
  int            m_idx;
  int            m_wr;
  logic          m_tready;
  logic          m_we;
  logic          m_acc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [31:0]   m_tstamp;
  logic [31:0]   m_cyc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void takeBeat();
    if (m_idx % (m_decim + 1) == 0) begin
      m_we   = 1'b1;
      m_addr = AW'(m_wr);
      m_din  = s_tdata;
      m_wr++;
      if (m_wr == m_len) m_state = S_DONE;
    end
    m_idx++;
  endfunction

  always @(posedge clk) begin
    tb_cyc++;
    if (!aresetn) begin
      m_state = S_IDLE; m_len = 0; m_decim = 0; m_idx = 0; m_wr = 0;
      m_tready = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
      m_tstamp = '0; m_cyc = '0;
    end else begin
      m_acc = s_tvalid && m_tready;
      m_we  = 1'b0;
      if (abort) begin
        m_state = S_IDLE;
      end else if (m_state == S_IDLE || m_state == S_DONE) begin
        if (arm) begin
          m_state = S_ARMED;
          m_len   = int'(cfg_len);
          m_decim = int'(cfg_decim);
          m_wr    = 0;
        end
      end else if (m_state == S_ARMED) begin
        if (trigger) begin
`ifdef ADC_CAPTURE_TSTAMP_EN
          m_tstamp = m_cyc;
`endif
          if (m_len == 0) begin
            m_state = S_DONE;
          end else begin
            m_state = S_CAPTURE;
            m_idx   = 0;
            if (m_acc) takeBeat();
          end
        end
      end else if (m_acc) begin
        takeBeat();
      end
      m_cyc    = m_cyc + 32'd1;
      m_tready = 1'b1;
    end
  end

  // Compare on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!aresetn) begin
      checkOutput("rst_tready", 64'(s_tready), 64'd0);
      checkOutput("rst_we", 64'(bram_we), 64'd0);
      checkOutput("rst_addr", 64'(bram_addr), 64'd0);
      checkOutput("rst_din", 64'(bram_din), 64'd0);
      checkOutput("rst_status", 64'({armed, busy, done}), 64'd0);
      checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
      checkOutput("rst_tstamp", 64'(trig_tstamp), 64'd0);
    end else begin
      checkOutput("tready", 64'(s_tready), 64'(m_tready));
      checkOutput("bram_we", 64'(bram_we), 64'(m_we));
      checkOutput("bram_addr", 64'(bram_addr), 64'(m_addr));
      checkOutput("bram_din", 64'(bram_din), 64'(m_din));
      checkOutput("armed", 64'(armed), 64'(m_state == S_ARMED));
      checkOutput("busy", 64'(busy), 64'(m_state == S_CAPTURE));
      checkOutput("done", 64'(done), 64'(m_state == S_DONE));
      checkOutput("wr_count", 64'(wr_count), 64'(m_wr));
      checkOutput("trig_tstamp", 64'(trig_tstamp), 64'(m_tstamp));
      if (bram_we) wr_log.push_back('{tb_cyc, bram_addr, bram_din});
    end
  end

  task automatic applyStimulus(input logic a, input logic t, input logic ab, input logic v,
                               input logic [DW-1:0] d);
    arm = a; trigger = t; abort = ab; s_tvalid = v; s_tdata = d;
    drive_cyc = tb_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic checkLog(input string name, input int idx, input int cyc,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (idx < wr_log.size()) begin
      checkOutput({name, "_addr"}, 64'(wr_log[idx].addr), 64'(addr));
      checkOutput({name, "_data"}, 64'(wr_log[idx].data), 64'(data));
      checkOutput({name, "_cyc"}, 64'(wr_log[idx].cyc), 64'(cyc));
    end else begin
      checkOutput({name, "_present"}, 64'd0, 64'd1);
    end
  endtask

  int t0;
  int ts;

  initial begin
    aresetn = 1'b0; arm = 0; trigger = 0; abort = 0; s_tvalid = 0; s_tdata = '0;
    cfg_len = '0; cfg_decim = '0;
    #2;
    checkOutput("por_tready", 64'(s_tready), 64'd0);
    resetDut();
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("tready_after_rst", 64'(s_tready), 64'd1);

    // len 4, no decimation, continuous beats
    cfg_len = 8'd4; cfg_decim = 8'd0;
    applyStimulus(1, 0, 0, 1, 32'hDEAD_0000);
    wr_log.delete();
    applyStimulus(0, 1, 0, 1, BASE);
    t0 = drive_cyc;
    for (int k = 1; k < 8; k++) applyStimulus(0, 0, 0, 1, BASE + DW'(k));
    checkOutput("s1_nwrites", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) checkLog("s1", i, t0 + 1 + i, AW'(i), BASE + DW'(i));
    checkOutput("s1_done", 64'(done), 64'd1);
    checkOutput("s1_wr_count", 64'(wr_count), 64'd4);

    // len 3, decim 2: beats 0,3,6
    cfg_len = 8'd3; cfg_decim = 8'd2;
    applyStimulus(1, 0, 0, 1, 32'hDEAD_0001);
    wr_log.delete();
    applyStimulus(0, 1, 0, 1, BASE);
    t0 = drive_cyc;
    for (int k = 1; k < 10; k++) applyStimulus(0, 0, 0, 1, BASE + DW'(k));
    checkOutput("s2_nwrites", 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) checkLog("s2", i, t0 + 1 + 3 * i, AW'(i), BASE + DW'(3 * i));
    checkOutput("s2_done", 64'(done), 64'd1);

    // len 4, tvalid toggling
    cfg_len = 8'd4; cfg_decim = 8'd0;
    applyStimulus(1, 0, 0, 1, 32'hDEAD_0002);
    wr_log.delete();
    applyStimulus(0, 1, 0, 1, BASE);
    t0 = drive_cyc;
    for (int k = 1; k < 10; k++) applyStimulus(0, 0, 0, (k % 2 == 0), BASE + DW'(k));
    checkOutput("s3_nwrites", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) checkLog("s3", i, t0 + 1 + 2 * i, AW'(i), BASE + DW'(2 * i));

    // abort in second CAPTURE cycle, then arm+abort together
    cfg_len = 8'd8; cfg_decim = 8'd0;
    applyStimulus(1, 0, 0, 1, 32'hDEAD_0003);
    wr_log.delete();
    applyStimulus(0, 1, 0, 1, BASE);
    applyStimulus(0, 0, 0, 1, BASE + 1);
    applyStimulus(0, 0, 1, 1, BASE + 2);
    applyStimulus(0, 0, 0, 1, BASE + 3);
    applyStimulus(1, 0, 1, 1, BASE + 4);
    for (int k = 5; k < 9; k++) applyStimulus(0, 1, 0, 1, BASE + DW'(k));
    checkOutput("s4_nwrites", 64'(wr_log.size()), 64'd2);
    checkOutput("s4_wr_count", 64'(wr_count), 64'd2);
    checkOutput("s4_status", 64'({armed, busy, done}), 64'd0);

    // len 0: trigger goes straight to done; trigger in IDLE ignored
    cfg_len = 8'd0;
    applyStimulus(1, 0, 0, 1, 32'hDEAD_0004);
    wr_log.delete();
    applyStimulus(0, 1, 0, 1, BASE);
    applyStimulus(0, 0, 0, 1, BASE + 1);
    checkOutput("s5_done", 64'(done), 64'd1);
    checkOutput("s5_nwrites", 64'(wr_log.size()), 64'd0);
    checkOutput("s5_wr_count", 64'(wr_count), 64'd0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 1, 0, 1, BASE + 2);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("s5_idle_trig", 64'({armed, busy, done}), 64'd0);

    // reset mid-capture, then trigger without re-arm
    cfg_len = 8'd8;
    applyStimulus(1, 0, 0, 1, 32'hDEAD_0005);
    wr_log.delete();
    applyStimulus(0, 1, 0, 1, BASE);
    applyStimulus(0, 0, 0, 1, BASE + 1);
    applyStimulus(0, 0, 0, 0, BASE + 2);
    s_tvalid = 1'b1;
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 1, BASE + DW'(k));
    checkOutput("s6_nwrites", 64'(wr_log.size()), 64'd2);
    checkOutput("s6_status", 64'({armed, busy, done}), 64'd0);
    checkOutput("s6_wr_count", 64'(wr_count), 64'd0);

    // trigger 100 cycles after reset release
    resetDut();
    cfg_len = 8'd2;
    for (int k = 0; k < 99; k++) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 1, BASE);
    ts = int'(trig_tstamp);
`ifdef ADC_CAPTURE_TSTAMP_EN
    checkOutput("tstamp_near_100", 64'(ts >= 99 && ts <= 101), 64'd1);
`else
    checkOutput("tstamp_zero", 64'(ts), 64'd0);
`endif

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cfg_len   = AW'($urandom_range(0, 10));
      cfg_decim = 8'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, DW'($urandom));
    end
    applyStimulus(0, 0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_buf.md
ADC_CAPTURE_BUF -- requirements
Module: adc_capture_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 256: width of the ADC AXI4-stream beat and of the BRAM write word.
REQ-002 Parameter ADDR_WIDTH, default 13: BRAM word address width; capture depth is up to 2^ADDR_WIDTH-1 words.
REQ-003 Port clk, input, 1: single clock for all logic (ADC stream clock).
REQ-004 Port aresetn, input, 1: reset, asynchronous and active-low.
REQ-005 Port s_tdata, input, DATA_WIDTH: ADC sample beat, AXI4-stream slave, connected to adc20axis.
REQ-006 Port s_tvalid, input, 1: beat valid.
REQ-007 Port s_tready, output, 1: beat accepted.
REQ-008 Port arm, input, 1: single-cycle pulse that arms a capture.
REQ-009 Port trigger, input, 1: single-cycle pulse that starts capture when armed.
REQ-010 Port abort, input, 1: single-cycle pulse that returns to idle from any state.
REQ-011 Port cfg_len, input, ADDR_WIDTH: number of words to store; sampled on arm.
REQ-012 Port cfg_decim, input, 8: store one beat in every cfg_decim+1 accepted beats; sampled on arm.
REQ-013 Port bram_addr, output, ADDR_WIDTH: BRAM write address.
REQ-014 Port bram_din, output, DATA_WIDTH: BRAM write data.
REQ-015 Port bram_we, output, 1: BRAM write enable.
REQ-016 Port armed / busy / done, output, 1 each: status, one-hot with idle.
REQ-017 Port wr_count, output, ADDR_WIDTH: words written in the current or most recent capture.
REQ-018 Port trig_tstamp, output, 32: cycle timestamp of the last accepted trigger.

Function
REQ-019 States SHALL be IDLE, ARMED, CAPTURE, DONE; armed=ARMED, busy=CAPTURE, done=DONE, registered.
REQ-020 arm in IDLE or DONE -> ARMED, latch cfg_len/cfg_decim, clear wr_count; arm in ARMED or CAPTURE ignored.
REQ-021 trigger in ARMED -> CAPTURE and reset the decimation counter; trigger in any other state ignored.
REQ-022 abort -> IDLE from any state, next cycle; abort beats arm or trigger in the same cycle; wr_count is held.
REQ-023 s_tready SHALL be 1 in every state after reset release; beats outside CAPTURE are discarded.
REQ-024 In CAPTURE, a beat (s_tvalid&s_tready) is stored when the decimation counter is 0; the counter wraps from cfg_decim to 0.
REQ-025 The beat accepted in the trigger cycle SHALL be the first candidate beat (decimation index 0).
REQ-026 A stored beat SHALL appear on bram_din/bram_addr with bram_we=1 exactly one cycle after acceptance; first address 0, then +1 per store.
REQ-027 When wr_count reaches the latched cfg_len, the state SHALL go CAPTURE->DONE in the cycle after the last store; no further writes.
REQ-028 cfg_len=0: trigger goes ARMED->DONE directly, with zero writes.
REQ-029 Gaps in s_tvalid SHALL NOT advance the decimation counter or the address.

Reset
REQ-030 On aresetn low: state IDLE, s_tready=0, bram_we=0, bram_addr=0, bram_din=0, wr_count=0, status outputs 0, trig_tstamp=0, latched config=0.
REQ-031 Reset asserted mid-capture SHALL abort with no further bram_we pulse; after release, arm is required again.

Configuration
REQ-032 Macro ADC_CAPTURE_TSTAMP_EN: when defined, a free-running 32-bit cycle counter (wraps at 2^32) is latched into trig_tstamp on each accepted trigger.
REQ-033 When ADC_CAPTURE_TSTAMP_EN is undefined, trig_tstamp SHALL be constant 0 and the counter is absent; all other behaviour is unchanged.

Verification
REQ-034 cfg_len=4, cfg_decim=0, continuous beats D0..: arm, trigger with D0 -> writes D0..D3 at addr 0..3, one cycle late, then done=1, wr_count=4.
REQ-035 cfg_len=3, cfg_decim=2, continuous beats -> stores beats 0,3,6 at addr 0,1,2.
REQ-036 cfg_len=4, tvalid toggling 1,0,1,0 -> 4 writes with contiguous addresses; no write in gap cycles.
REQ-037 abort in cycle 2 of CAPTURE, and arm+abort in the same cycle -> IDLE with no further bram_we; wr_count=2.
REQ-038 cfg_len=0 -> trigger gives done=1 and zero writes; trigger in IDLE -> no state change.
REQ-039 With ADC_CAPTURE_TSTAMP_EN, trigger 100 cycles after reset release -> trig_tstamp=100 (+/-1 by the counter start convention); without the macro -> trig_tstamp=0.
